// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store unit driving a req/gnt/rvalid data bus with pipeline stall.
// Optional misaligned-access trap enabled by defining MISALIGN_TRAP_EN.
module mem_access_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic [2:0]  funct3_in,
  input  logic [31:0] addr_in,
  input  logic [31:0] store_data_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] load_data_out,
  output logic        lsu_stall,
  output logic        bus_err,
  output logic        misalign_exc
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT_R} state_t;
  state_t state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        we_q, we_d;
  logic        access, is_w, is_h, mis, issue, tmo, req_c, stall_c;
  logic [1:0]  off;
  logic [3:0]  be_c;
  logic [31:0] wdata_c, fmt;
  logic [7:0]  b;
  logic [15:0] h;

  assign access  = mem_read_in | mem_write_in;
  assign off     = addr_in[1:0];
  assign is_w    = funct3_in[1];
  assign is_h    = funct3_in[1:0] == 2'b01;
  assign be_c    = (!mem_write_in || is_w) ? 4'b1111 : is_h ? (off[1] ? 4'b1100 : 4'b0011) : 4'b0001 << off;
  assign wdata_c = !mem_write_in ? '0 : is_w ? store_data_in : is_h ? {2{store_data_in[15:0]}} : {4{store_data_in[7:0]}};
`ifdef MISALIGN_TRAP_EN
  assign mis = access & ((is_h & off[0]) | (is_w & (|off)));
`else
  assign mis = 1'b0;
`endif
  assign issue = access & !mis;
  assign tmo   = cnt_q == 16'(TIMEOUT_CYCLES - 1);
  // Load formatting reads EX/MEM directly: it is frozen while the access is outstanding.
  assign b   = dmem_rdata[{off, 3'b000} +: 8];
  assign h   = off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
  assign fmt = is_w ? dmem_rdata : is_h ? {{16{h[15] & !funct3_in[2]}}, h} : {{24{b[7] & !funct3_in[2]}}, b};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      we_q    <= we_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    we_d    = we_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (issue && !dmem_gnt) begin
          state_d = REQ;
          addr_d  = {addr_in[31:2], 2'b00};
          wdata_d = wdata_c;
          be_d    = be_c;
          we_d    = mem_write_in;
        end else if (issue && mem_read_in) state_d = WAIT_R;
      end
      REQ: begin
        if (dmem_gnt) begin
          state_d = we_q ? IDLE : WAIT_R;
          cnt_d   = '0;
        end else if (tmo) state_d = IDLE;
      end
      WAIT_R: state_d = (dmem_rvalid || tmo) ? IDLE : WAIT_R;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_c         = 1'b0;
    stall_c       = 1'b0;
    dmem_we       = 1'b0;
    dmem_addr     = '0;
    dmem_be       = '0;
    dmem_wdata    = '0;
    load_data_out = '0;
    bus_err       = 1'b0;
    misalign_exc  = 1'b0;
    case (state_q)
      IDLE: begin
        req_c        = issue;
        stall_c      = issue & !(mem_write_in & dmem_gnt);
        dmem_we      = issue & mem_write_in;
        dmem_addr    = issue ? {addr_in[31:2], 2'b00} : '0;
        dmem_be      = issue ? be_c : '0;
        dmem_wdata   = issue ? wdata_c : '0;
        misalign_exc = mis;
      end
      REQ: begin
        req_c      = 1'b1;
        stall_c    = dmem_gnt ? !we_q : !tmo;
        dmem_we    = we_q;
        dmem_addr  = addr_q;
        dmem_be    = be_q;
        dmem_wdata = wdata_q;
        bus_err    = tmo & !dmem_gnt;
      end
      WAIT_R: begin
        stall_c       = !dmem_rvalid & !tmo;
        bus_err       = tmo & !dmem_rvalid;
        load_data_out = dmem_rvalid ? fmt : '0;
      end
      default: ;
    endcase
  end

  // Request and stall must drop the instant reset asserts, even if EX/MEM still shows an access.
  assign dmem_req  = rst_n & req_c;
  assign lsu_stall = rst_n & stall_c;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: randomized and directed check of mem_access_unit against a transaction-level model.
module tb_mem_access_unit;
  localparam int T = 6;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        mem_read_in = 1'b0, mem_write_in = 1'b0;
  logic [2:0]  funct3_in = '0;
  logic [31:0] addr_in = '0, store_data_in = '0;
  logic        dmem_req, dmem_we, dmem_gnt = 1'b0, dmem_rvalid = 1'b0;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = '0, load_data_out;
  logic [3:0]  dmem_be;
  logic        lsu_stall, bus_err, misalign_exc;
  int n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .funct3_in(funct3_in), .addr_in(addr_in), .store_data_in(store_data_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .load_data_out(load_data_out), .lsu_stall(lsu_stall),
    .bus_err(bus_err), .misalign_exc(misalign_exc)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ld_val(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v;
    if (f3[1]) return rd;
    if (f3[0]) begin
      v = (rd >> (int'(a[1]) * 16)) & 32'hFFFF;
      if (!f3[2] && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = (rd >> (int'(a[1:0]) * 8)) & 32'hFF;
      if (!f3[2] && v[7]) v = v | 32'hFFFF_FF00;
    end
    return v;
  endfunction

  // gd: cycles until gnt (0 = same cycle); rd: cycles from gnt to rvalid (>=1).
  task automatic txn(input logic wr, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                     input logic [31:0] rdat, input int gd, input int rd);
    logic mis, tmo, exp_req;
    logic [3:0] be;
    logic [31:0] wd, lv;
    int e;
    mis = 1'b0;
`ifdef MISALIGN_TRAP_EN
    mis = (f3[1:0] == 2'b01 && a[0]) || (f3[1] && a[1:0] != 2'b00);
`endif
    be = (!wr || f3[1]) ? 4'hF : f3[0] ? (a[1] ? 4'hC : 4'h3) : 4'(1 << a[1:0]);
    wd = f3[1] ? d : f3[0] ? {2{d[15:0]}} : {4{d[7:0]}};
    lv = ld_val(f3, a, rdat);
    if (mis) begin e = 0; tmo = 1'b0; end
    else if (gd > T) begin e = T; tmo = 1'b1; end
    else if (wr) begin e = gd; tmo = 1'b0; end
    else if (rd > T) begin e = gd + T; tmo = 1'b1; end
    else begin e = gd + rd; tmo = 1'b0; end
    for (int c = 0; c <= e; c++) begin
      @(negedge clk);
      mem_read_in   = !wr;
      mem_write_in  = wr;
      funct3_in     = f3;
      addr_in       = a;
      store_data_in = d;
      dmem_gnt      = (c == gd);
      dmem_rvalid   = !wr && ((c == gd + rd) || (c <= gd && $urandom_range(0, 1) == 1));
      dmem_rdata    = (c == gd + rd) ? rdat : $urandom;
      #1;
      exp_req = !mis && c <= gd;
      chk("stall", 32'(lsu_stall), 32'(c < e));
      chk("req", 32'(dmem_req), 32'(exp_req));
      if (exp_req) begin
        chk("we", 32'(dmem_we), 32'(wr));
        chk("addr", dmem_addr, {a[31:2], 2'b00});
        chk("be", 32'(dmem_be), 32'(be));
        if (wr) chk("wdata", dmem_wdata, wd);
      end
      chk("bus_err", 32'(bus_err), 32'(tmo && c == e));
      chk("load_data", load_data_out, (!wr && !tmo && !mis && c == e) ? lv : 32'h0);
      chk("misalign", 32'(misalign_exc), 32'(mis && c == 0));
    end
    @(negedge clk);
    mem_read_in = 1'b0; mem_write_in = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    #1;
    chk("idle_stall", 32'(lsu_stall), 32'h0);
    chk("idle_req", 32'(dmem_req), 32'h0);
  endtask

  initial begin
    @(negedge clk); #1;
    chk("rst_req", 32'(dmem_req), 32'h0);
    chk("rst_stall", 32'(lsu_stall), 32'h0);
    chk("rst_be", 32'(dmem_be), 32'h0);
    chk("rst_addr", dmem_addr, 32'h0);
    chk("rst_load", load_data_out, 32'h0);
    chk("rst_err", 32'({bus_err, misalign_exc, dmem_we}), 32'h0);
    @(negedge clk); rst_n = 1'b1;
    txn(1'b1, 3'b010, 32'h104, 32'hDEADBEEF, 32'h0, 0, 1);
    txn(1'b1, 3'b000, 32'h103, 32'h000000A5, 32'h0, 3, 1);
    txn(1'b0, 3'b000, 32'h102, 32'h0, 32'h0080FF00, 0, 2);
    txn(1'b0, 3'b101, 32'h102, 32'h0, 32'h0080FF00, 1, 2);
    txn(1'b0, 3'b010, 32'h100, 32'h0, 32'h12345678, 0, T + 1);
    txn(1'b0, 3'b001, 32'h101, 32'h0, 32'h12348765, 1, 1);
    txn(1'b1, 3'b010, 32'h200, 32'h11223344, 32'h0, T + 2, 1);
    txn(1'b1, 3'b001, 32'h206, 32'hCAFEBABE, 32'h0, T, 1);
    txn(1'b0, 3'b100, 32'h301, 32'h0, 32'hFFFF80FF, 0, T);
    // Reset asserted while the request is outstanding, then a stale rvalid arrives.
    @(negedge clk);
    mem_read_in = 1'b1; funct3_in = 3'b010; addr_in = 32'h400; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    #1 chk("pre_rst_stall", 32'(lsu_stall), 32'h1);
    @(negedge clk); #1 chk("pre_rst_req", 32'(dmem_req), 32'h1);
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("mid_rst_req", 32'(dmem_req), 32'h0);
    chk("mid_rst_stall", 32'(lsu_stall), 32'h0);
    @(negedge clk);
    mem_read_in = 1'b0; rst_n = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFFFFFF;
    #1;
    chk("stale_load", load_data_out, 32'h0);
    chk("stale_stall", 32'(lsu_stall), 32'h0);
    @(negedge clk); dmem_rvalid = 1'b0;
    for (int i = 0; i < 80; i++) begin
      logic w;
      w = 1'($urandom_range(0, 1));
      txn(w, w ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
          ($urandom_range(0, 3) == 0) ? $urandom_range(0, T + 2) : $urandom_range(0, 2),
          ($urandom_range(0, 4) == 0) ? T + 1 : $urandom_range(1, 3));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
